// File: rtl/param_chain_loader_pkg.sv
// Shared definitions for the neuron parameter-chain loader: chain geometry helpers and FSM states.
package param_chain_loader_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    function automatic int unsigned chain_bits(input int unsigned neurons,
                                               input int unsigned inputs,
                                               input int unsigned bias_bits);
        return neurons * (inputs + bias_bits);
    endfunction

    function automatic int unsigned load_bytes(input int unsigned bits);
        return (bits + 7) / 8;
    endfunction

    // Valid bits carried by the final byte of a load (8 when the chain is a whole number of bytes).
    function automatic int unsigned tail_bits(input int unsigned bits);
        return (bits % 8 == 0) ? 8 : bits % 8;
    endfunction

    localparam int unsigned CHAIN_BITS = chain_bits(8, 8, 3);
    localparam int unsigned LOAD_BYTES = load_bytes(CHAIN_BITS);

endpackage

// File: rtl/param_chain_loader_byte_serializer.sv
// 8-bit parallel-load, MSB-first shift register with a valid-bit count and early ready.
module param_chain_loader_byte_serializer (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic [3:0] nbits_i,
    input  logic       shift_i,
    output logic       bit_o,
    output logic       valid_o,
    output logic       ready_o
);

    logic [7:0] sr_q, sr_d;
    logic [3:0] cnt_q, cnt_d;

    // A load may overlap the shift of the last valid bit, giving gapless streaming.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (load_i) begin
            sr_d  = data_i;
            cnt_d = nbits_i;
        end else if (shift_i && cnt_q != 4'd0) begin
            sr_d  = {sr_q[6:0], 1'b0};
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign bit_o   = sr_q[7];
    assign valid_o = cnt_q != 4'd0;
    assign ready_o = cnt_q <= 4'd1;

endmodule

// File: rtl/param_chain_loader.sv
// Serialises parameter bytes onto the neuron setup/param shift chain and returns the
// bits falling out of the far end as readback bytes.
module param_chain_loader
    import param_chain_loader_pkg::*;
#(
    parameter int unsigned NEURONS   = 8,
    parameter int unsigned INPUTS    = 8,
    parameter int unsigned BIAS_BITS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       setup,
    output logic       param_out,
    input  logic       chain_in,
    output logic [7:0] readback_data,
    output logic       readback_valid,
    output logic       busy,
    output logic       done
);

    localparam int unsigned NUM_BITS  = chain_bits(NEURONS, INPUTS, BIAS_BITS);
    localparam int unsigned NUM_BYTES = load_bytes(NUM_BITS);
    localparam int unsigned CNT_W     = $clog2(NUM_BITS + 1);
    localparam int unsigned BYTE_W    = $clog2(NUM_BYTES + 1);
    localparam logic [3:0]  TAIL      = 4'(tail_bits(NUM_BITS));

    state_e            state_q;
    logic [CNT_W-1:0]  rem_q;
    logic [BYTE_W-1:0] bytes_left_q;
    logic [7:0]        col_q;
    logic [2:0]        col_cnt_q;

    logic       ser_bit, ser_valid, ser_ready;
    logic       accept, shift, last_byte, last_sample;
    logic [3:0] ser_nbits, col_n;
    logic [7:0] col_cat;

    assign in_ready    = (state_q == StLoad) && ser_ready && (bytes_left_q != '0);
    assign accept      = in_ready && in_valid;
    assign shift       = (state_q == StLoad) && ser_valid;
    assign last_byte   = bytes_left_q == BYTE_W'(1);
    assign ser_nbits   = last_byte ? TAIL : 4'd8;
    assign col_cat     = {col_q[6:0], chain_in};
    assign col_n       = {1'b0, col_cnt_q} + 4'd1;
    // rem_q reaches zero once the final bit is on param_out; that cycle's sample is the last.
    assign last_sample = setup && (rem_q == '0);

    param_chain_loader_byte_serializer u_tx (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (state_q != StLoad),
        .load_i  (accept),
        .data_i  (in_data),
        .nbits_i (ser_nbits),
        .shift_i (shift),
        .bit_o   (ser_bit),
        .valid_o (ser_valid),
        .ready_o (ser_ready)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            rem_q          <= '0;
            bytes_left_q   <= '0;
            col_q          <= '0;
            col_cnt_q      <= '0;
            setup          <= 1'b0;
            param_out      <= 1'b0;
            readback_data  <= '0;
            readback_valid <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            setup          <= 1'b0;
            done           <= 1'b0;
            readback_valid <= 1'b0;

            // Partial final group is left-aligned with zero padding.
            if (setup) begin
                if (col_n == 4'd8 || last_sample) begin
                    readback_data  <= col_cat << (4'd8 - col_n);
                    readback_valid <= 1'b1;
                    col_q          <= '0;
                    col_cnt_q      <= '0;
                end else begin
                    col_q     <= col_cat;
                    col_cnt_q <= col_cnt_q + 3'd1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= StLoad;
                        rem_q        <= CNT_W'(NUM_BITS);
                        bytes_left_q <= BYTE_W'(NUM_BYTES);
                        busy         <= 1'b1;
                    end
                end
                StLoad: begin
                    if (shift) begin
                        setup     <= 1'b1;
                        param_out <= ser_bit;
                        rem_q     <= rem_q - CNT_W'(1);
                    end
                    if (accept) begin
                        bytes_left_q <= bytes_left_q - BYTE_W'(1);
                    end
                    if (last_sample) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/param_chain_loader.md
Name: param_chain_loader

Overview:
- Drives the serial parameter shift chain formed by the neurons' setup/param_in/param_out daisy-chain.
- Accepts parameter bytes over a valid/ready handshake and serialises them MSB-first onto the chain, asserting setup only on cycles that carry a real bit.
- Simultaneously captures the bits falling out of the chain's far end and returns them as readback bytes, so the previous contents can be verified.
- Sits between the chip's input pins/host interface and the neuron array.

Parameters:
- NEURONS, 8, number of neurons in the chain.
- INPUTS, 8, weights per neuron.
- BIAS_BITS, 3, bias bits per neuron.
- CHAIN_BITS, NEURONS*(INPUTS+BIAS_BITS), total chain length in bits (derived, do not override).

Ports:
- clk  in  1  single system clock; all state changes on posedge.
- rst_n  in  1  reset (already decided): synchronous, active-low.
- start  in  1  one-cycle pulse; begins a load; ignored while busy.
- in_data  in  8  parameter byte; bit 7 is transmitted first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- setup  out  1  registered; chain shifts on the next posedge when high.
- param_out  out  1  registered serial bit to the first neuron's param_in.
- chain_in  in  1  last neuron's param_out.
- readback_data  out  8  byte shifted out of the chain, first-out bit in bit 7.
- readback_valid  out  1  one-cycle pulse; readback_data is valid.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the final chain bit has shifted.

Behaviour:
- Reset values: in_ready=0, setup=0, param_out=0, readback_data=0, readback_valid=0, busy=0, done=0; bit counter=0; state=IDLE.
- Reset at any point, including mid-load, returns to IDLE. setup is forced low from the next edge. Chain contents are left partially shifted and are not cleared.
- States:
  - IDLE: in_ready=0, setup=0. On start go to LOAD, clear the bit counter (remaining = CHAIN_BITS), set busy.
  - LOAD: shift byte bits out, one per cycle. in_ready=1 when the byte register is empty, or when its last valid bit is being driven this cycle (gapless streaming). A byte is accepted on in_valid&in_ready. When no byte is available, setup=0 and the chain holds (stall, no bubble bit).
  - DONE: a single cycle. done=1, busy drops, return to IDLE.
- Latency: a byte accepted at edge N drives setup=1 with param_out=bit7 during cycle N+1, through bit0 during cycle N+8.
- With in_valid held high, setup stays high for exactly CHAIN_BITS consecutive cycles.
- Bits per load: exactly CHAIN_BITS. Bytes consumed = ceil(CHAIN_BITS/8); the default 88 bits takes 11 bytes.
  - If CHAIN_BITS mod 8 ≠ 0, only the upper (CHAIN_BITS mod 8) bits of the final byte are sent; the rest are discarded.
  - in_ready stays low once the final byte has been accepted.
- Ordering: the first bit sent lands in the last neuron's bias MSB. The final bit sent lands in neuron 0's weights[0].
- Readback:
  - On every cycle where setup=1, chain_in is sampled into an 8-bit collector, MSB first.
  - Each 8th sample produces readback_valid=1 next cycle, with readback_data holding the full byte.
  - A partial final group is left-aligned, zero-padded, and emitted in the same cycle as the last shift.
  - Readback has no back-pressure.
- done asserts the cycle after the last setup=1 cycle.
- start during LOAD or DONE is ignored.
- start coinciding with reset: reset wins.
- Counter width: clog2(CHAIN_BITS+1).

Decomposition:
- Shared package/include:
  - CHAIN_BITS and LOAD_BYTES=ceil(CHAIN_BITS/8) localparams.
  - State encoding (IDLE, LOAD, DONE).
- Sub-module: byte_serializer, an 8-bit parallel-load, MSB-first shift register with a valid-bit count and an early-ready output. It is instantiated once for TX; RX collection stays inline.

Test Plan:
- Reset then idle: in_valid=1, no start → in_ready=0 and setup=0 for 20 cycles; all outputs at reset values.
- Back-to-back load with defaults and bytes 0x00..0x0A, valid always high → setup high for exactly 88 consecutive cycles. The param_out stream equals the bytes MSB-first, with only the top 0 bits of byte 10 omitted (88 = 11×8, so all bits sent). done pulses once, busy low afterwards.
- Round trip: load pattern A=0xA5 repeated, then load B=0x3C repeated → the second load's 11 readback bytes all equal 0xA5, via a behavioural 88-bit chain model.
- Stall: drop in_valid for 5 cycles after byte 3 → setup=0 exactly those cycles, no duplicated or lost bits, total setup cycles still 88.
- Non-multiple length: NEURONS=3 (33 bits), 5 bytes → 33 setup cycles, only bit7 of byte 4 sent. The last readback byte is left-aligned with 7 zero pad bits.
- Reset mid-load at bit 40 → setup=0 next cycle, busy=0, no done. A fresh start then completes a full 88-bit load normally.
